main_memory_ctrl: RTL and testbench
===================================

# main_memory_ctrl

Sequencer and two-port arbiter for the 4 KB banked SRAM main memory. Grants one of two requesters (instruction fetch on port 0, data on port 1) round-robin, latches the winning request, and drives the memory array's chip-enable, output-enable, write, read-driver and staging-register strobes through read, full-word write, and read-modify-write (sub-word) sequences. Returns a one-cycle `ready` pulse to the granted requester.

## Interface
- `SRAM_WAIT`, default 3: cycles CE/OE or CE/WR are held per SRAM access; legal range 1–15.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `r0_en`, `r1_en`  in  1  request valid, held until that port's ready
- `r0_rd_wr`, `r1_rd_wr`  in  1  1 = read, 0 = write
- `r0_wr_size`, `r1_wr_size`  in  2  0 byte, 1 half, 2/3 word
- `r0_addr`, `r1_addr`  in  32  byte address
- `r0_ready`, `r1_ready`  out  1  one-cycle completion pulse
- `grant`  out  2  one-hot owner of memory data bus, steers external data mux
- `mem_addr`  out  32  latched address to array
- `mem_wr_size`  out  2  latched size to aligner
- `ctrl_ce`, `ctrl_oe`, `ctrl_wr`  out  1  array strobes, active-high
- `ctrl_rd`  out  1  enables array-to-requester read driver
- `reg_wr`  out  1  staging-register load strobe

## Operation
- States: IDLE, RD_ACC, RD_DONE, WR_FETCH, WR_LATCH, WR_DRIVE, WR_DONE.
- IDLE: arbitrate. On grant, latch addr/rd_wr/size, set `grant`, load `wait_cnt = SRAM_WAIT-1`.
  - Read → RD_ACC.
  - Word write → WR_DRIVE.
  - Byte/half write → WR_FETCH.
- RD_ACC: ce=oe=1; decrement; at 0 → RD_DONE.
- RD_DONE: ce=oe=ctrl_rd=1, ready=1 → IDLE.
- WR_FETCH: ce=oe=1; count as RD_ACC → WR_LATCH.
- WR_LATCH: ce=oe=reg_wr=1 for one cycle → WR_DRIVE, reload counter.
- WR_DRIVE: ce=ctrl_wr=1 (oe=0); count → WR_DONE.
- WR_DONE: ready=1, strobes 0 → IDLE.
- Arbitration: round-robin via `last_grant` flop.
  - Single request wins.
  - Both requesting: grant goes to the port not granted last.
  - `last_grant` updates on each grant.
- `grant` holds from the grant edge through the DONE state; it is 0 in IDLE.
- After grant, `rN_en`, addr and size are ignored until IDLE. Dropping `en` mid-transaction does not abort; ready still pulses.
- Requesters deassert `en` on the edge they sample ready=1. If `en` is still high in the following IDLE cycle, it is a new request.
- Word write with `addr[1:0]` ≠ 0 is performed as an aligned word write. Sub-word accesses crossing a word boundary are undetected (requester responsibility). Addresses above 4 KB alias in the array.
- `ctrl_oe` and `ctrl_wr` are never high in the same cycle. `ctrl_rd` is only high in RD_DONE.

## Timing
- Reset: state IDLE, all outputs 0 (`grant` = 2'b00, `mem_addr` = 0), `last_grant` = port 1, so port 0 wins the first tie.
- Reset mid-transaction: abort with no ready; strobes drop on the reset edge.
- All outputs are registered-state decodes with no combinational path from `rN_en` to outputs.
- Latency from the edge sampling `en` in IDLE (W = SRAM_WAIT) to the cycle with ready=1:
  - Read and word write: W+1 cycles.
  - Sub-word write: 2W+2 cycles.
- After a transaction, one IDLE bubble precedes the next grant.
- Counter width: 4 bits, no wrap; SRAM_WAIT=1 gives a single-cycle access state.

## Structure
- `main_memory_pkg`: state encoding constants, size encodings (`SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=3, 2 treated as word), `RD`=1/`WR`=0.
- Sub-module `rr_arbiter2`: inputs two requests, `last_grant`, and IDLE enable; outputs one-hot grant. Purely combinational, with the flop kept in the parent.
- Parent holds the FSM, wait counter, and request latch.

## Test plan
- Read, SRAM_WAIT=3: r0 read at 0x104 → ce/oe high 4 cycles, ctrl_rd with ready in the 4th cycle, mem_addr=0x104, grant=01.
- Word write: r1 write at 0x200 size 3 → WR_DRIVE 3 cycles with ctrl_wr, oe never high, r1_ready at cycle 4, no reg_wr.
- Byte write: r1 at 0x203 size 0 → 3 fetch cycles, reg_wr exactly 1 cycle, 3 write cycles, ready at cycle 8.
- Contention: r0 and r1 requesting continuously from reset → grants alternate 01, 10, 01, with one IDLE cycle between transactions and no starvation.
- Abort: assert reset in WR_DRIVE → next cycle all strobes 0, no ready; the next r0 request wins the tie.
- Drop en: r0 drops en during RD_ACC → transaction completes, r0_ready pulses once, no second grant.

Source files
------------

// File: rtl/main_memory_pkg.sv
// main_memory_pkg: shared types and encodings for the
// main memory sequencer and its arbiter.
package main_memory_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_DONE,
    WR_FETCH,
    WR_LATCH,
    WR_DRIVE,
    WR_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd3;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  localparam int CNT_W = 4;

  // sizes 2 and 3 both mean a full word
  function automatic logic is_word(input logic [1:0] sz);
    return sz[1];
  endfunction

endpackage

// File: rtl/main_memory_ctrl_if.sv
// main_memory_ctrl_if: two requester ports plus the
// array strobes and latched address driven by the ctrl.
interface main_memory_ctrl_if;
  logic        r0_en;
  logic        r1_en;
  logic        r0_rd_wr;
  logic        r1_rd_wr;
  logic [1:0]  r0_wr_size;
  logic [1:0]  r1_wr_size;
  logic [31:0] r0_addr;
  logic [31:0] r1_addr;
  logic        r0_ready;
  logic        r1_ready;
  logic [1:0]  grant;
  logic [31:0] mem_addr;
  logic [1:0]  mem_wr_size;
  logic        ctrl_ce;
  logic        ctrl_oe;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic        reg_wr;

  modport master (
    output r0_en, r1_en, r0_rd_wr, r1_rd_wr,
    output r0_wr_size, r1_wr_size, r0_addr, r1_addr,
    input  r0_ready, r1_ready, grant,
    input  mem_addr, mem_wr_size,
    input  ctrl_ce, ctrl_oe, ctrl_wr, ctrl_rd, reg_wr
  );

  modport slave (
    input  r0_en, r1_en, r0_rd_wr, r1_rd_wr,
    input  r0_wr_size, r1_wr_size, r0_addr, r1_addr,
    output r0_ready, r1_ready, grant,
    output mem_addr, mem_wr_size,
    output ctrl_ce, ctrl_oe, ctrl_wr, ctrl_rd, reg_wr
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; the last_grant
// flop lives in the parent so this stays combinational.
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // one-hot pick, ties go to the port not served last
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      !en:                    gnt = 2'b00;
      en && req0 && req1:     gnt = last_grant ? 2'b01 : 2'b10;
      en && req0 && !req1:    gnt = 2'b01;
      en && !req0 && req1:    gnt = 2'b10;
      default:                gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: arbitrates two requesters and sequences
// SRAM read, word write and read-modify-write strobes.
module main_memory_ctrl
  import main_memory_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 3
) (
  input logic              clk,
  input logic              reset,
  main_memory_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LD =
    CNT_W'(SRAM_WAIT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic [1:0]       grant_q, grant_nxt;
  logic [1:0]       arb_gnt;
  logic             last_grant, last_nxt;
  logic [31:0]      addr_q, addr_nxt;
  logic             rd_wr_q, rd_wr_nxt;
  logic [1:0]       size_q, size_nxt;
  logic [31:0]      sel_addr;
  logic             sel_rd_wr;
  logic [1:0]       sel_size;
  logic             cnt_zero;

  rr_arbiter2 u_arb (
    .req0       (bus.r0_en),
    .req1       (bus.r1_en),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .gnt        (arb_gnt)
  );

  assign sel_addr  = arb_gnt[1] ? bus.r1_addr : bus.r0_addr;
  assign sel_rd_wr = arb_gnt[1] ? bus.r1_rd_wr : bus.r0_rd_wr;
  assign sel_size  = arb_gnt[1] ? bus.r1_wr_size
                                : bus.r0_wr_size;
  assign cnt_zero  = (wait_cnt == '0);

  // next state, wait counter and request latch
  always_comb begin
    state_nxt = state;
    cnt_nxt   = wait_cnt;
    grant_nxt = grant_q;
    last_nxt  = last_grant;
    addr_nxt  = addr_q;
    rd_wr_nxt = rd_wr_q;
    size_nxt  = size_q;
    unique case (state)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          grant_nxt = arb_gnt;
          last_nxt  = arb_gnt[1];
          cnt_nxt   = CNT_LD;
          addr_nxt  = sel_addr;
          rd_wr_nxt = sel_rd_wr;
          size_nxt  = sel_size;
          if (sel_rd_wr == RD)
            state_nxt = RD_ACC;
          else if (is_word(sel_size))
            state_nxt = WR_DRIVE;
          else
            state_nxt = WR_FETCH;
        end
      end
      RD_ACC: begin
        if (cnt_zero) state_nxt = RD_DONE;
        else          cnt_nxt   = wait_cnt - 1'b1;
      end
      RD_DONE: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
      WR_FETCH: begin
        if (cnt_zero) state_nxt = WR_LATCH;
        else          cnt_nxt   = wait_cnt - 1'b1;
      end
      WR_LATCH: begin
        state_nxt = WR_DRIVE;
        cnt_nxt   = CNT_LD;
      end
      WR_DRIVE: begin
        if (cnt_zero) state_nxt = WR_DONE;
        else          cnt_nxt   = wait_cnt - 1'b1;
      end
      WR_DONE: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // state, counter, grant owner and latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      grant_q    <= 2'b00;
      last_grant <= 1'b1;
      addr_q     <= '0;
      rd_wr_q    <= WR;
      size_q     <= SZ_BYTE;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= cnt_nxt;
      grant_q    <= grant_nxt;
      last_grant <= last_nxt;
      addr_q     <= addr_nxt;
      rd_wr_q    <= rd_wr_nxt;
      size_q     <= size_nxt;
    end
  end

  // array strobes decoded from registered state only
  always_comb begin
    bus.ctrl_ce  = 1'b0;
    bus.ctrl_oe  = 1'b0;
    bus.ctrl_wr  = 1'b0;
    bus.ctrl_rd  = 1'b0;
    bus.reg_wr   = 1'b0;
    bus.r0_ready = 1'b0;
    bus.r1_ready = 1'b0;
    unique case (state)
      RD_ACC, WR_FETCH: begin
        bus.ctrl_ce = 1'b1;
        bus.ctrl_oe = 1'b1;
      end
      RD_DONE: begin
        bus.ctrl_ce  = 1'b1;
        bus.ctrl_oe  = 1'b1;
        bus.ctrl_rd  = 1'b1;
        bus.r0_ready = grant_q[0];
        bus.r1_ready = grant_q[1];
      end
      WR_LATCH: begin
        bus.ctrl_ce = 1'b1;
        bus.ctrl_oe = 1'b1;
        bus.reg_wr  = 1'b1;
      end
      WR_DRIVE: begin
        bus.ctrl_ce = 1'b1;
        bus.ctrl_wr = 1'b1;
      end
      WR_DONE: begin
        bus.r0_ready = grant_q[0];
        bus.r1_ready = grant_q[1];
      end
      default: ;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_size = size_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: directed scenarios with hand-computed
// expectations for the main memory sequencer.
module tb_main_memory_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  main_memory_ctrl_if bus ();
  main_memory_ctrl_if bus1 ();

  main_memory_ctrl #(.SRAM_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  main_memory_ctrl #(.SRAM_WAIT(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.r0_en = 1'b0;
    bus.r1_en = 1'b0;
    bus1.r0_en = 1'b0;
    bus1.r1_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.grant !== 2'b00) begin
      failures++;
      $display("FAIL reset_grant got=%b exp=00", bus.grant);
    end
    checks++;
    if (bus.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=0", bus.mem_addr);
    end
    checks++;
    if ({bus.ctrl_ce, bus.ctrl_oe, bus.ctrl_wr, bus.ctrl_rd,
         bus.reg_wr, bus.r0_ready, bus.r1_ready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=0",
        {bus.ctrl_ce, bus.ctrl_oe, bus.ctrl_wr, bus.ctrl_rd,
         bus.reg_wr, bus.r0_ready, bus.r1_ready});
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    int ce_n = 0, oe_n = 0, rd_n = 0, rd_c = 0;
    int rdy_n = 0, rdy_c = 0, r1_n = 0;
    logic [1:0] g1 = 2'b00;
    logic [31:0] a1 = 32'h0;
    do_reset();
    bus.r0_en = 1'b1;
    bus.r0_rd_wr = 1'b1;
    bus.r0_wr_size = 2'd3;
    bus.r0_addr = 32'h104;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin g1 = bus.grant; a1 = bus.mem_addr; end
      if (bus.ctrl_ce) ce_n++;
      if (bus.ctrl_oe) oe_n++;
      if (bus.ctrl_rd) begin rd_n++; rd_c = c; end
      if (bus.r1_ready) r1_n++;
      if (bus.r0_ready) begin
        rdy_n++; rdy_c = c; bus.r0_en = 1'b0;
      end
    end
    checks++;
    if (ce_n !== 4) begin failures++;
      $display("FAIL read_ce got=%0d exp=4", ce_n); end
    checks++;
    if (oe_n !== 4) begin failures++;
      $display("FAIL read_oe got=%0d exp=4", oe_n); end
    checks++;
    if (rd_n !== 1 || rd_c !== 4) begin failures++;
      $display("FAIL read_ctrl_rd got=%0d@%0d exp=1@4", rd_n, rd_c); end
    checks++;
    if (rdy_n !== 1 || rdy_c !== 4) begin failures++;
      $display("FAIL read_ready got=%0d@%0d exp=1@4", rdy_n, rdy_c); end
    checks++;
    if (r1_n !== 0) begin failures++;
      $display("FAIL read_r1_ready got=%0d exp=0", r1_n); end
    checks++;
    if (g1 !== 2'b01) begin failures++;
      $display("FAIL read_grant got=%b exp=01", g1); end
    checks++;
    if (a1 !== 32'h104) begin failures++;
      $display("FAIL read_addr got=%h exp=104", a1); end
  endtask

  task automatic test_word_write();
    int ce_n = 0, oe_n = 0, wr_n = 0, reg_n = 0, ovl = 0;
    int rdy_n = 0, rdy_c = 0;
    logic [1:0] g1 = 2'b00;
    do_reset();
    bus.r1_en = 1'b1;
    bus.r1_rd_wr = 1'b0;
    bus.r1_wr_size = 2'd3;
    bus.r1_addr = 32'h200;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) g1 = bus.grant;
      if (bus.ctrl_ce) ce_n++;
      if (bus.ctrl_oe) oe_n++;
      if (bus.ctrl_wr) wr_n++;
      if (bus.reg_wr) reg_n++;
      if (bus.ctrl_oe && bus.ctrl_wr) ovl++;
      if (bus.r1_ready) begin
        rdy_n++; rdy_c = c; bus.r1_en = 1'b0;
      end
    end
    checks++;
    if (wr_n !== 3) begin failures++;
      $display("FAIL wword_wr got=%0d exp=3", wr_n); end
    checks++;
    if (oe_n !== 0 || ovl !== 0) begin failures++;
      $display("FAIL wword_oe got=%0d/%0d exp=0/0", oe_n, ovl); end
    checks++;
    if (reg_n !== 0) begin failures++;
      $display("FAIL wword_reg_wr got=%0d exp=0", reg_n); end
    checks++;
    if (ce_n !== 3) begin failures++;
      $display("FAIL wword_ce got=%0d exp=3", ce_n); end
    checks++;
    if (rdy_n !== 1 || rdy_c !== 4) begin failures++;
      $display("FAIL wword_ready got=%0d@%0d exp=1@4", rdy_n, rdy_c); end
    checks++;
    if (g1 !== 2'b10) begin failures++;
      $display("FAIL wword_grant got=%b exp=10", g1); end
  endtask

  task automatic test_byte_write();
    int ce_n = 0, oe_n = 0, wr_n = 0, wr_c = 0, ovl = 0;
    int reg_n = 0, reg_c = 0, rdy_n = 0, rdy_c = 0;
    logic [1:0] s1 = 2'b11;
    logic [31:0] a1 = 32'h0;
    do_reset();
    bus.r1_en = 1'b1;
    bus.r1_rd_wr = 1'b0;
    bus.r1_wr_size = 2'd0;
    bus.r1_addr = 32'h203;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin s1 = bus.mem_wr_size; a1 = bus.mem_addr; end
      if (bus.ctrl_ce) ce_n++;
      if (bus.ctrl_oe) oe_n++;
      if (bus.ctrl_wr) begin wr_n++; if (wr_c == 0) wr_c = c; end
      if (bus.reg_wr) begin reg_n++; reg_c = c; end
      if (bus.ctrl_oe && bus.ctrl_wr) ovl++;
      if (bus.r1_ready) begin
        rdy_n++; rdy_c = c; bus.r1_en = 1'b0;
      end
    end
    checks++;
    if (oe_n !== 4) begin failures++;
      $display("FAIL wbyte_oe got=%0d exp=4", oe_n); end
    checks++;
    if (reg_n !== 1 || reg_c !== 4) begin failures++;
      $display("FAIL wbyte_reg_wr got=%0d@%0d exp=1@4", reg_n, reg_c); end
    checks++;
    if (wr_n !== 3 || wr_c !== 5) begin failures++;
      $display("FAIL wbyte_wr got=%0d@%0d exp=3@5", wr_n, wr_c); end
    checks++;
    if (ce_n !== 7) begin failures++;
      $display("FAIL wbyte_ce got=%0d exp=7", ce_n); end
    checks++;
    if (ovl !== 0) begin failures++;
      $display("FAIL wbyte_overlap got=%0d exp=0", ovl); end
    checks++;
    if (rdy_n !== 1 || rdy_c !== 8) begin failures++;
      $display("FAIL wbyte_ready got=%0d@%0d exp=1@8", rdy_n, rdy_c); end
    checks++;
    if (s1 !== 2'd0) begin failures++;
      $display("FAIL wbyte_size got=%0d exp=0", s1); end
    checks++;
    if (a1 !== 32'h203) begin failures++;
      $display("FAIL wbyte_addr got=%h exp=203", a1); end
  endtask

  task automatic test_contention();
    logic [1:0] g [1:15];
    logic [31:0] a6 = 32'h0;
    int r0_n = 0, r1_n = 0;
    do_reset();
    bus.r0_en = 1'b1; bus.r0_rd_wr = 1'b1;
    bus.r0_addr = 32'h10; bus.r0_wr_size = 2'd3;
    bus.r1_en = 1'b1; bus.r1_rd_wr = 1'b1;
    bus.r1_addr = 32'h20; bus.r1_wr_size = 2'd3;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      g[c] = bus.grant;
      if (c == 6) a6 = bus.mem_addr;
      if (bus.r0_ready) r0_n++;
      if (bus.r1_ready) r1_n++;
    end
    bus.r0_en = 1'b0;
    bus.r1_en = 1'b0;
    checks++;
    if (g[1] !== 2'b01) begin failures++;
      $display("FAIL cont_g1 got=%b exp=01", g[1]); end
    checks++;
    if (g[5] !== 2'b00) begin failures++;
      $display("FAIL cont_idle1 got=%b exp=00", g[5]); end
    checks++;
    if (g[6] !== 2'b10) begin failures++;
      $display("FAIL cont_g2 got=%b exp=10", g[6]); end
    checks++;
    if (g[10] !== 2'b00) begin failures++;
      $display("FAIL cont_idle2 got=%b exp=00", g[10]); end
    checks++;
    if (g[11] !== 2'b01) begin failures++;
      $display("FAIL cont_g3 got=%b exp=01", g[11]); end
    checks++;
    if (a6 !== 32'h20) begin failures++;
      $display("FAIL cont_addr got=%h exp=20", a6); end
    checks++;
    if (r0_n !== 2 || r1_n !== 1) begin failures++;
      $display("FAIL cont_ready got=%0d/%0d exp=2/1", r0_n, r1_n); end
  endtask

  task automatic test_abort();
    int rdy_n = 0;
    logic wr1 = 1'b0;
    do_reset();
    bus.r1_en = 1'b1; bus.r1_rd_wr = 1'b0;
    bus.r1_wr_size = 2'd3; bus.r1_addr = 32'h300;
    @(negedge clk);
    wr1 = bus.ctrl_wr;
    if (bus.r0_ready || bus.r1_ready) rdy_n++;
    @(negedge clk);
    if (bus.r0_ready || bus.r1_ready) rdy_n++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (wr1 !== 1'b1) begin failures++;
      $display("FAIL abort_in_drive got=%b exp=1", wr1); end
    checks++;
    if ({bus.ctrl_ce, bus.ctrl_oe, bus.ctrl_wr, bus.ctrl_rd,
         bus.reg_wr} !== 5'b0) begin failures++;
      $display("FAIL abort_strobes got=%b exp=0",
        {bus.ctrl_ce, bus.ctrl_oe, bus.ctrl_wr, bus.ctrl_rd, bus.reg_wr});
    end
    if (bus.r0_ready || bus.r1_ready) rdy_n++;
    checks++;
    if (rdy_n !== 0) begin failures++;
      $display("FAIL abort_ready got=%0d exp=0", rdy_n); end
    checks++;
    if (bus.grant !== 2'b00) begin failures++;
      $display("FAIL abort_grant got=%b exp=00", bus.grant); end
    reset = 1'b0;
    bus.r0_en = 1'b1; bus.r0_rd_wr = 1'b1;
    bus.r0_wr_size = 2'd3; bus.r0_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (bus.grant !== 2'b01) begin failures++;
      $display("FAIL abort_tie got=%b exp=01", bus.grant); end
    bus.r0_en = 1'b0;
    bus.r1_en = 1'b0;
  endtask

  task automatic test_drop_en();
    int rdy_n = 0, rdy_c = 0, g_n = 0;
    do_reset();
    bus.r0_en = 1'b1; bus.r0_rd_wr = 1'b1;
    bus.r0_wr_size = 2'd3; bus.r0_addr = 32'h80;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) bus.r0_en = 1'b0;
      if (bus.grant != 2'b00) g_n++;
      if (bus.r0_ready) begin rdy_n++; rdy_c = c; end
    end
    checks++;
    if (rdy_n !== 1) begin failures++;
      $display("FAIL drop_ready_n got=%0d exp=1", rdy_n); end
    checks++;
    if (rdy_c !== 4) begin failures++;
      $display("FAIL drop_ready_c got=%0d exp=4", rdy_c); end
    checks++;
    if (g_n !== 4) begin failures++;
      $display("FAIL drop_grant_cycles got=%0d exp=4", g_n); end
  endtask

  task automatic test_wait1();
    int ce_n = 0, rdy_c = 0, reg_n = 0, wr_n = 0, wrdy_c = 0;
    do_reset();
    bus1.r0_en = 1'b1; bus1.r0_rd_wr = 1'b1;
    bus1.r0_wr_size = 2'd3; bus1.r0_addr = 32'h8;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus1.ctrl_ce) ce_n++;
      if (bus1.r0_ready) begin rdy_c = c; bus1.r0_en = 1'b0; end
    end
    checks++;
    if (rdy_c !== 2) begin failures++;
      $display("FAIL w1_read_ready got=%0d exp=2", rdy_c); end
    checks++;
    if (ce_n !== 2) begin failures++;
      $display("FAIL w1_read_ce got=%0d exp=2", ce_n); end
    do_reset();
    bus1.r1_en = 1'b1; bus1.r1_rd_wr = 1'b0;
    bus1.r1_wr_size = 2'd1; bus1.r1_addr = 32'h6;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (bus1.reg_wr) reg_n++;
      if (bus1.ctrl_wr) wr_n++;
      if (bus1.r1_ready) begin wrdy_c = c; bus1.r1_en = 1'b0; end
    end
    checks++;
    if (wrdy_c !== 4) begin failures++;
      $display("FAIL w1_half_ready got=%0d exp=4", wrdy_c); end
    checks++;
    if (reg_n !== 1) begin failures++;
      $display("FAIL w1_half_reg_wr got=%0d exp=1", reg_n); end
    checks++;
    if (wr_n !== 1) begin failures++;
      $display("FAIL w1_half_wr got=%0d exp=1", wr_n); end
  endtask

  initial begin
    bus.r0_en = 1'b0; bus.r1_en = 1'b0;
    bus.r0_rd_wr = 1'b1; bus.r1_rd_wr = 1'b1;
    bus.r0_wr_size = 2'd0; bus.r1_wr_size = 2'd0;
    bus.r0_addr = 32'h0; bus.r1_addr = 32'h0;
    bus1.r0_en = 1'b0; bus1.r1_en = 1'b0;
    bus1.r0_rd_wr = 1'b1; bus1.r1_rd_wr = 1'b1;
    bus1.r0_wr_size = 2'd0; bus1.r1_wr_size = 2'd0;
    bus1.r0_addr = 32'h0; bus1.r1_addr = 32'h0;
    test_reset();
    test_read();
    test_word_write();
    test_byte_write();
    test_contention();
    test_abort();
    test_drop_en();
    test_wait1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
